tick_gen_multi: RTL and testbench

Parametrised, multi-channel successor to the fixed 1 Hz/5 Hz tick generator. A shared prescaler divides clk_in down to a base tick rate. NUM_CH independent channel dividers, each runtime-programmable, derive per-channel one-cycle tick strobes and 50% square outputs from that base tick. It feeds display refresh, blink and timekeeping logic with phase-coherent ticks from one clock domain.

---
 rtl/tick_gen_multi.sv | 143 ++++++++++++++
 tb/tb_tick_gen_multi.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tick_gen_multi
//
// Multi-channel tick generator. A shared prescaler divides clk_in down to a
// base tick. Each channel divides the base tick again by its own runtime
// divisor. The result is a one-cycle tick strobe and a 50% square wave per
// channel. All ticks are phase-coherent with base_tick.
//
// Ports:
//   clk_in      - sole clock, rising edge
//   reset       - synchronous, active-high reset
//   enable      - high: counters advance; low: all counters freeze
//   restart     - realign prescaler, channel counters and square outputs
//   div_values  - packed divisors, channel i at [i*DIV_W +: DIV_W]
//   div_load    - latch div_values into the per-channel shadow divisors
//   base_tick   - one-cycle strobe at BASE_RATE_HZ
//   tick        - per-channel one-cycle strobe, coincident with base_tick
//   square      - per-channel output, toggles on each tick of that channel
// ---------------------------------------------------------------------------
module tick_gen_multi #(
  parameter int CLK_IN_RATE_HZ = 100_000_000,
  parameter int BASE_RATE_HZ   = 100,
  parameter int NUM_CH         = 4,
  parameter int DIV_W          = 8
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    restart,
  input  logic [NUM_CH*DIV_W-1:0] div_values,
  input  logic                    div_load,
  output logic                    base_tick,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       square
);

  localparam int PRESCALE = CLK_IN_RATE_HZ / BASE_RATE_HZ;
  localparam int PCNT_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  // Reject parameter sets that cannot produce an exact base rate.
  if ((CLK_IN_RATE_HZ % BASE_RATE_HZ) != 0) begin : g_bad_ratio
    $error("tick_gen_multi: CLK_IN_RATE_HZ must be a multiple of BASE_RATE_HZ");
  end
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("tick_gen_multi: PRESCALE must be at least 2");
  end
  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("tick_gen_multi: NUM_CH must be at least 1");
  end

  // -------------------------------------------------------------------------
  // Shared prescaler
  // -------------------------------------------------------------------------
  logic [PCNT_W-1:0] pcnt_reg;
  logic [PCNT_W-1:0] pcnt_next;
  logic              base_tick_reg;
  logic              base_strobe;

  // base_strobe is the unregistered base event. Every registered output in
  // this module is derived from it, so all ticks line up with base_tick.
  assign base_strobe = enable && (pcnt_reg == PCNT_LAST);

  always_comb begin
    pcnt_next = pcnt_reg;
    if (base_strobe) begin
      pcnt_next = '0;
    end else if (enable) begin
      pcnt_next = pcnt_reg + PCNT_W'(1);
    end
  end

  // div_load does not touch the prescaler. A load that coincides with the
  // strobe still produces base_tick.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pcnt_reg      <= '0;
      base_tick_reg <= 1'b0;
    end else if (restart) begin
      pcnt_reg      <= '0;
      base_tick_reg <= 1'b0;
    end else begin
      pcnt_reg      <= pcnt_next;
      base_tick_reg <= base_strobe;
    end
  end

  assign base_tick = base_tick_reg;

  // -------------------------------------------------------------------------
  // Channel dividers
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DIV_W-1:0] div_reg;
      logic [DIV_W-1:0] ccnt_reg;
      logic             tick_reg;
      logic             square_reg;
      logic             ch_wrap;

      // The counter stays below the divisor, so ccnt never overflows.
      // A divisor of 0 parks the channel at ccnt = 0 with square held.
      assign ch_wrap = (ccnt_reg == div_reg - DIV_W'(1));

      always_ff @(posedge clk_in) begin
        if (reset) begin
          div_reg    <= '0;
          ccnt_reg   <= '0;
          tick_reg   <= 1'b0;
          square_reg <= 1'b0;
        end else if (restart) begin
          // Realignment keeps the programmed divisor.
          ccnt_reg   <= '0;
          tick_reg   <= 1'b0;
          square_reg <= 1'b0;
        end else if (div_load) begin
          // A new divisor restarts the channel phase. Its tick is suppressed
          // even when this cycle carries a base strobe.
          div_reg    <= div_values[gi*DIV_W +: DIV_W];
          ccnt_reg   <= '0;
          tick_reg   <= 1'b0;
          square_reg <= 1'b0;
        end else begin
          tick_reg <= 1'b0;
          if (base_strobe && (div_reg != '0)) begin
            if (ch_wrap) begin
              ccnt_reg   <= '0;
              tick_reg   <= 1'b1;
              square_reg <= ~square_reg;
            end else begin
              ccnt_reg <= ccnt_reg + DIV_W'(1);
            end
          end
        end
      end

      assign tick[gi]   = tick_reg;
      assign square[gi] = square_reg;
    end
  endgenerate

endmodule

// File: tb/tb_tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_tick_gen_multi
//
// Scoreboard bench for tick_gen_multi with PRESCALE = 10, three channels and
// 4-bit divisors. The stimulus process drives directed events. For each one
// it queues the hand-derived rising-edge index of every expected base_tick
// pulse, together with the tick/square pattern at that pulse.
//
// The pattern at a pulse follows from the pulse index n, counted since the
// last load or realign, and the divisor d:
//   tick   = (n % d == 0)
//   square = parity of n / d
//
// The monitor pops one entry whenever the DUT shows a pulse. Quiet-time
// states (reset, pause, restart) are probed directly.
// ---------------------------------------------------------------------------
module tb_tick_gen_multi;

  localparam int NCH = 3;
  localparam int DW  = 4;

  logic            clk        = 1'b0;
  logic            reset      = 1'b1;
  logic            enable     = 1'b0;
  logic            restart    = 1'b0;
  logic            div_load   = 1'b0;
  logic [NCH*DW-1:0] div_values = '0;
  logic            base_tick;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  square;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int             edge_no;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] square;
  } exp_t;

  exp_t exp_q[$];
  int   bdiv[NCH];

  tick_gen_multi #(
    .CLK_IN_RATE_HZ(100),
    .BASE_RATE_HZ  (10),
    .NUM_CH        (NCH),
    .DIV_W         (DW)
  ) dut (
    .clk_in    (clk),
    .reset     (reset),
    .enable    (enable),
    .restart   (restart),
    .div_values(div_values),
    .div_load  (div_load),
    .base_tick (base_tick),
    .tick      (tick),
    .square    (square)
  );

  always #5 clk = ~clk;

  // cyc equals k after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NCH-1:0] exp_tick(input int n);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bdiv[i] != 0) begin
        if ((n % bdiv[i]) == 0) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [NCH-1:0] exp_sq(input int n);
    logic [NCH-1:0] r;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      if (bdiv[i] != 0) begin
        if (((n / bdiv[i]) % 2) == 1) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic push_pulse(input int e, input int n);
    exp_q.push_back('{e, exp_tick(n), exp_sq(n)});
  endtask

  task automatic push_raw(input int e, input logic [NCH-1:0] t,
                          input logic [NCH-1:0] s);
    exp_q.push_back('{e, t, s});
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  // Wait until just after rising edge e. Inputs set afterwards are first
  // sampled at edge e+1.
  task automatic run_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every visible pulse consumes one scoreboard entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (base_tick !== 1'b0 || tick !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse at edge %0d: base=%b tick=%b, required no pulse",
                 cyc, base_tick, tick);
      end else begin
        e = exp_q.pop_front();
        $display("pulse at edge %0d (expected %0d): base=%b tick=%b square=%b",
                 cyc, e.edge_no, base_tick, tick, square);
        check("pulse_edge",   cyc,       e.edge_no);
        check("pulse_base",   base_tick, 1'b1);
        check("pulse_tick",   tick,      e.tick);
        check("pulse_square", square,    e.square);
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < NCH; i++) bdiv[i] = 0;

    // Reset state.
    run_to(2);
    @(negedge clk);
    check("reset_base",   base_tick, 1'b0);
    check("reset_tick",   tick,      3'b000);
    check("reset_square", square,    3'b000);

    // 1: free run with no divisors. Pulses come 10 edges after release.
    run_to(3);
    reset  = 1'b0;
    enable = 1'b1;
    push_pulse(13, 1);
    push_pulse(23, 2);
    push_pulse(33, 3);

    // 2: load {ch0=1, ch1=5, ch2=10}, sampled at edge 36.
    run_to(35);
    div_values = {4'd10, 4'd5, 4'd1};
    div_load   = 1'b1;
    bdiv[0] = 1;
    bdiv[1] = 5;
    bdiv[2] = 10;
    for (int n = 1; n <= 11; n++) push_pulse(33 + 10 * n, n);
    run_to(36);
    div_load = 1'b0;

    // 3: pause 7 cycles at pcnt = 4. Edge 153 slips to 160.
    run_to(147);
    enable = 1'b0;
    push_pulse(160, 12);
    push_pulse(170, 13);
    run_to(150);
    @(negedge clk);
    check("pause_square", square,    exp_sq(11));
    check("pause_base",   base_tick, 1'b0);
    run_to(154);
    enable = 1'b1;

    // 4: restart at edge 175, with ch1 ccnt = 3. Base at 185, tick1 at 225.
    run_to(174);
    restart = 1'b1;
    for (int n = 1; n <= 6; n++) push_pulse(175 + 10 * n, n);
    run_to(175);
    restart = 1'b0;
    @(negedge clk);
    check("restart_square", square,    3'b000);
    check("restart_base",   base_tick, 1'b0);

    // 5: load ch1 = 2 coincident with the strobe of edge 245. tick1 at 265.
    run_to(244);
    div_values = {4'd10, 4'd2, 4'd1};
    div_load   = 1'b1;
    push_raw(245, 3'b000, 3'b000);
    bdiv[1] = 2;
    for (int n = 1; n <= 5; n++) push_pulse(245 + 10 * n, n);
    run_to(245);
    div_load = 1'b0;

    // 6: reset mid-run, then restart and load together.
    run_to(297);
    reset = 1'b1;
    run_to(298);
    @(negedge clk);
    check("midreset_base",   base_tick, 1'b0);
    check("midreset_tick",   tick,      3'b000);
    check("midreset_square", square,    3'b000);
    for (int i = 0; i < NCH; i++) bdiv[i] = 0;
    run_to(299);
    reset = 1'b0;
    push_pulse(309, 1);
    push_pulse(319, 2);

    // The load is ignored, so the shadow divisors stay 0.
    run_to(321);
    restart    = 1'b1;
    div_load   = 1'b1;
    div_values = {4'd1, 4'd1, 4'd1};
    push_pulse(332, 1);
    push_pulse(342, 2);
    run_to(322);
    restart  = 1'b0;
    div_load = 1'b0;

    run_to(350);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
